mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mips_mem_pkg.sv | 39 +++
 rtl/lsu_load_align.sv | 38 +++
 rtl/mem_access_unit.sv | 149 ++++++++++++++
 tb/tb_mem_access_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_mem_pkg
// Description : Access-size encodings, FSM state type and byte-lane helpers
//               shared by the memory access unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

  localparam logic [1:0] BYTE = 2'b00;
  localparam logic [1:0] HALF = 2'b01;
  localparam logic [1:0] WORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Little-endian byte enables for an access of the given size at addr[1:0].
  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      BYTE:    return 4'b0001 << lo;
      HALF:    return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data replicated across every lane so the byte enables alone pick the target.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    case (size)
      BYTE:    return {4{data[7:0]}};
      HALF:    return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_load_align
// Description : Extracts the addressed byte/half lane of a memory word and
//               sign- or zero-extends it to 32 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (addr_lo)
      2'd0:    w_byte = word[7:0];
      2'd1:    w_byte = word[15:8];
      2'd2:    w_byte = word[23:16];
      default: w_byte = word[31:24];
    endcase
    w_half = addr_lo[1] ? word[31:16] : word[15:0];

    case (size)
      BYTE:    data = {{24{sign & w_byte[7]}}, w_byte};
      HALF:    data = {{16{sign & w_half[15]}}, w_half};
      default: data = word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Load/store unit between the EX stage and a single-cycle-ack
//               data memory: alignment checks, byte lanes, timeout bus error.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int AW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic          rd_en,
  input  logic          wr_en,
  input  logic [1:0]    word_size,
  input  logic          load_signed,
  output logic          stall,
  output logic          done,
  output logic [31:0]   rdata,
  output logic          misaligned,
  output logic          bus_error,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ack
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] c_cnt_limit = CNT_W'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [AW-1:0]     r_addr;
  logic [31:0]       r_wdata;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [31:0]       r_rdata;
  logic              r_misaligned;
  logic              r_bus_error;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_accept;
  logic              w_illegal;
  logic              w_timeout;
  logic [31:0]       w_load;

  // Reset gates acceptance so stall is 0 while rst is held, even with start high.
  assign w_accept  = (r_state == IDLE) && start && (rd_en || wr_en) && !rst;
  assign w_timeout = (r_cnt == c_cnt_limit);

  always_comb begin
    case (word_size)
      BYTE:    w_illegal = 1'b0;
      HALF:    w_illegal = addr[0];
      WORD:    w_illegal = (addr[1:0] != 2'b00);
      default: w_illegal = 1'b1;
    endcase
    w_illegal = w_illegal | (rd_en & wr_en);
  end

  always_comb begin
    w_state_next = r_state;
    stall        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          stall        = 1'b1;
          w_state_next = w_illegal ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (mem_ack || w_timeout) w_state_next = RESP;
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_we         <= 1'b0;
      r_size       <= BYTE;
      r_signed     <= 1'b0;
      r_rdata      <= '0;
      r_misaligned <= 1'b0;
      r_bus_error  <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr       <= addr;
            r_wdata      <= wdata;
            r_we         <= wr_en;
            r_size       <= word_size;
            r_signed     <= load_signed;
            r_misaligned <= w_illegal;
            r_bus_error  <= 1'b0;
            r_rdata      <= '0;
            r_cnt        <= '0;
          end
        end
        ACCESS: begin
          // Ack takes priority over the timeout limit.
          if (mem_ack)        r_rdata     <= mem_rdata;
          else if (w_timeout) r_bus_error <= 1'b1;
          else                r_cnt       <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  lsu_load_align u_align (
    .word    (r_rdata),
    .addr_lo (r_addr[1:0]),
    .size    (r_size),
    .sign    (r_signed),
    .data    (w_load)
  );

  assign done       = (r_state == RESP);
  assign misaligned = done & r_misaligned;
  assign bus_error  = done & r_bus_error;
  assign rdata      = (done && !r_we && !r_misaligned && !r_bus_error) ? w_load : 32'd0;

  assign mem_req   = (r_state == ACCESS);
  assign mem_we    = mem_req & r_we;
  assign mem_addr  = mem_req ? {r_addr[AW-1:2], 2'b00} : '0;
  assign mem_be    = mem_req ? byte_enable(r_size, r_addr[1:0]) : 4'b0000;
  assign mem_wdata = (mem_req && r_we) ? store_lanes(r_size, r_wdata) : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Randomized self-checking bench for mem_access_unit against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rd_en;
  logic        wr_en;
  logic [1:0]  word_size;
  logic        load_signed;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        misaligned;
  logic        bus_error;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.AW(32), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .addr        (addr),
    .wdata       (wdata),
    .rd_en       (rd_en),
    .wr_en       (wr_en),
    .word_size   (word_size),
    .load_signed (load_signed),
    .stall       (stall),
    .done        (done),
    .rdata       (rdata),
    .misaligned  (misaligned),
    .bus_error   (bus_error),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_be      (mem_be),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: access rules in plain arithmetic.
  function automatic bit model_illegal(input logic [31:0] a, input logic [1:0] sz, input bit rd, input bit wr);
    int unsigned lo = a % 4;
    if (rd && wr) return 1;
    if (sz == 2) return 1;
    if (sz == 1 && (lo % 2) != 0) return 1;
    if (sz == 3 && lo != 0) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] model_be(input logic [31:0] a, input logic [1:0] sz);
    int unsigned lo = a % 4;
    if (sz == 0) return 32'(1 << lo);
    if (sz == 1) return 32'(3 << lo);
    return 32'd15;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [1:0] sz);
    if (sz == 0) return (w % 256) * 32'h0101_0101;
    if (sz == 1) return (w % 65536) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] m, input logic [31:0] a, input logic [1:0] sz, input bit sg);
    int unsigned sh = m >> (8 * (a % 4));
    int unsigned v;
    if (sz == 0) begin
      v = sh % 256;
      return (sg && v >= 128) ? 32'(v) - 32'd256 : 32'(v);
    end
    if (sz == 1) begin
      v = sh % 65536;
      return (sg && v >= 32768) ? 32'(v) - 32'd65536 : 32'(v);
    end
    return m;
  endfunction

  // One transaction, entered and left just after a falling edge with the DUT idle.
  // d = cycle offset of the ack within ACCESS; negative or >= TO means no ack.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input bit rd, input bit wr,
                         input logic [1:0] sz, input bit sg, input int d, input logic [31:0] m);
    bit acc   = rd || wr;
    bit ill   = model_illegal(a, sz, rd, wr);
    bit acked = (d >= 0) && (d < TO);
    int dc    = ill ? 0 : (acked ? d + 1 : TO);
    logic [31:0] exp_rd;
    exp_rd = (rd && !wr && !ill && acked) ? model_load(m, a, sz, sg) : 32'd0;

    start = 1'b1; addr = a; wdata = wd; rd_en = rd; wr_en = wr;
    word_size = sz; load_signed = sg; mem_ack = 1'b0;
    #1;
    check("stall_at_start", {31'd0, stall}, {31'd0, acc});
    if (!acc) begin
      @(negedge clk);
      start = 1'b0;
      check("ignored_req", {31'd0, mem_req}, 32'd0);
      check("ignored_done", {31'd0, done}, 32'd0);
      return;
    end

    for (int k = 0; k <= dc + 1; k++) begin
      @(negedge clk);
      if (k <= dc) begin
        check("mem_req", {31'd0, mem_req}, {31'd0, (k < dc) && !ill});
        check("stall", {31'd0, stall}, {31'd0, (k < dc) && !ill});
        check("done", {31'd0, done}, {31'd0, k == dc});
        if (mem_req) begin
          check("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
          check("mem_be", {28'd0, mem_be}, model_be(a, sz));
          check("mem_we", {31'd0, mem_we}, {31'd0, wr});
          if (wr) check("mem_wdata", mem_wdata, model_store(wd, sz));
        end
        if (k == dc) begin
          check("rdata", rdata, exp_rd);
          check("misaligned", {31'd0, misaligned}, {31'd0, ill});
          check("bus_error", {31'd0, bus_error}, {31'd0, !ill && !acked});
        end
      end else begin
        check("after_resp_req", {31'd0, mem_req}, 32'd0);
        check("after_resp_done", {31'd0, done}, 32'd0);
        check("after_resp_flags", {30'd0, misaligned, bus_error}, 32'd0);
      end

      start = 1'b0;
      if (!ill && k == d && k < dc) begin
        mem_ack = 1'b1; mem_rdata = m;
      end else begin
        mem_ack = (k >= dc) ? 1'($urandom % 2) : 1'b0;
        mem_rdata = $urandom;
      end
      if (k == dc) begin
        // A start presented while in RESP must be ignored.
        start = 1'b1; rd_en = 1'b1; wr_en = 1'b0; word_size = 2'b11; addr = 32'h0;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; addr = '0; wdata = '0; rd_en = 1'b0; wr_en = 1'b0;
    word_size = 2'b00; load_signed = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_req", {30'd0, mem_req, mem_we}, 32'd0);
    check("rst_be", {28'd0, mem_be}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_txn(32'h1003, 32'h0, 1, 0, 2'b00, 1, 0, 32'h80FF_FF7F);
    run_txn(32'h2002, 32'h0, 1, 0, 2'b01, 0, 2, 32'hBEEF_1234);
    run_txn(32'h3001, 32'hAB, 0, 1, 2'b00, 0, 0, 32'h0);
    run_txn(32'h4002, 32'h0, 1, 0, 2'b11, 0, 0, 32'h0);
    run_txn(32'h4000, 32'h0, 1, 0, 2'b11, 0, -1, 32'h0);
    run_txn(32'h4004, 32'h0, 1, 0, 2'b11, 0, TO - 1, 32'h1234_5678);
    run_txn(32'h5001, 32'h0, 1, 0, 2'b01, 1, 0, 32'h0);
    run_txn(32'h5000, 32'h0, 1, 0, 2'b10, 0, 0, 32'h0);
    run_txn(32'h5000, 32'h0, 1, 1, 2'b11, 0, 0, 32'h0);
    run_txn(32'h5000, 32'h0, 0, 0, 2'b11, 0, 0, 32'h0);
    run_txn(32'h6002, 32'hCAFE_8001, 0, 1, 2'b01, 0, 1, 32'h0);
    run_txn(32'h7000, 32'h0, 1, 0, 2'b01, 1, 3, 32'h1111_8000);

    // Reset in the middle of an access.
    start = 1'b1; addr = 32'h8000; rd_en = 1'b1; wr_en = 1'b0; word_size = 2'b11; mem_ack = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("pre_rst_req", {31'd0, mem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_req", {31'd0, mem_req}, 32'd0);
    check("async_rst_stall", {31'd0, stall}, 32'd0);
    check("async_rst_be", {28'd0, mem_be}, 32'd0);
    check("async_rst_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_txn(32'h8000, 32'h0, 1, 0, 2'b11, 0, 0, 32'hDEAD_BEEF);

    for (int t = 0; t < 150; t++) begin
      int unsigned sel = $urandom % 10;
      int unsigned dsel = $urandom % 8;
      bit rd, wr;
      int d;
      if (sel == 0)      begin rd = 1; wr = 1; end
      else if (sel == 1) begin rd = 0; wr = 0; end
      else begin rd = 1'($urandom % 2); wr = !rd; end
      if (dsel == 0)      d = -1;
      else if (dsel == 1) d = TO - 1;
      else                d = int'($urandom % 5);
      run_txn($urandom, $urandom, rd, wr, 2'($urandom % 4), 1'($urandom % 2), d, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
